cmda_cmd_seq: RTL and testbench

Command/address sequencer for the DDR3 command/address lanes. It sits directly upstream of the per-pin single-bit CMD/address output cells. It queues DDR3 commands, issues each one for one clk_div cycle followed by a programmable number of NOP cycles, and drives the 4-bit parallel data and tristate nibble of every cmd/addr lane.

---
 rtl/cmda_cmd_seq_if.sv | 23 ++
 rtl/cmda_cmd_seq.sv | 161 ++++++++++++++++
 tb/tb_cmda_cmd_seq.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmda_cmd_seq_if.sv
// Command push interface of the DDR3 cmd/addr sequencer: valid/ready plus one command.
interface cmda_cmd_seq_if #(
  parameter int ADDRESS_NUMBER = 15,
  parameter int SKIP_BITS      = 8
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [2:0]                cmd_rcw;
  logic [2:0]                cmd_ba;
  logic [ADDRESS_NUMBER-1:0] cmd_addr;
  logic                      cmd_odt;
  logic [SKIP_BITS-1:0]      cmd_skip;

  modport master (
    output cmd_valid, cmd_rcw, cmd_ba, cmd_addr, cmd_odt, cmd_skip,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_rcw, cmd_ba, cmd_addr, cmd_odt, cmd_skip,
    output cmd_ready
  );
endinterface

// File: rtl/cmda_cmd_seq.sv
// DDR3 command/address sequencer: queues commands, issues each for one clk_div cycle
// followed by its NOP count, and drives the parallel/tristate nibbles of every cmd/addr lane.
module cmda_cmd_seq #(
  parameter int ADDRESS_NUMBER  = 15,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int SKIP_BITS       = 8
) (
  input  logic                                clk_div_i,
  input  logic                                rst_ni,
  input  logic                                en_i,
  input  logic                                cke_i,
  cmda_cmd_seq_if.slave                       cmd,
  output logic [(ADDRESS_NUMBER+9)*4-1:0]     cmda_din_o,
  output logic [(ADDRESS_NUMBER+9)*4-1:0]     cmda_tin_o,
  output logic                                busy_o,
  output logic [FIFO_DEPTH_LOG2:0]            fifo_level_o
);

  localparam int NUM_PINS = ADDRESS_NUMBER + 9;
  localparam int DEPTH    = 1 << FIFO_DEPTH_LOG2;

  typedef struct packed {
    logic [2:0]                rcw;
    logic [2:0]                ba;
    logic [ADDRESS_NUMBER-1:0] addr;
    logic                      odt;
    logic [SKIP_BITS-1:0]      skip;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_SKIP
  } state_e;

  entry_t                    mem_q [DEPTH];
  entry_t                    wr_entry;
  entry_t                    cur_q, cur_d;
  logic [FIFO_DEPTH_LOG2:0]  wr_ptr_q, rd_ptr_q, level;
  logic                      full, empty, push, pop, can_pop;
  state_e                    state_q, state_d;
  logic [SKIP_BITS-1:0]      cnt_q, cnt_d;

  logic [ADDRESS_NUMBER-1:0] addr_q;
  logic [2:0]                ba_q;
  logic [2:0]                rcw_q;
  logic                      cs_n_q, odt_q, cke_q, tz_q;
  logic [NUM_PINS-1:0]       pin_val, pin_tz;

  assign level         = wr_ptr_q - rd_ptr_q;
  assign full          = level[FIFO_DEPTH_LOG2];
  assign empty         = (level == '0);
  assign cmd.cmd_ready = rst_ni & ~full;
  assign push          = cmd.cmd_valid & cmd.cmd_ready;
  assign can_pop       = ~empty & en_i;
  assign wr_entry      = {cmd.cmd_rcw, cmd.cmd_ba, cmd.cmd_addr, cmd.cmd_odt, cmd.cmd_skip};
  assign cur_d         = pop ? mem_q[rd_ptr_q[FIFO_DEPTH_LOG2-1:0]] : cur_q;

  always_ff @(posedge clk_div_i) begin
    if (push) begin
      mem_q[wr_ptr_q[FIFO_DEPTH_LOG2-1:0]] <= wr_entry;
    end
  end

  always_ff @(posedge clk_div_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      cur_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (FIFO_DEPTH_LOG2+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (FIFO_DEPTH_LOG2+1)'(1);
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
    end
  end

  // SKIP exits on count 1 so the number of NOP cycles equals the programmed skip.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (can_pop) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cur_q.skip != '0) begin
          state_d = ST_SKIP;
          cnt_d   = cur_q.skip;
        end else if (can_pop) begin
          pop     = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SKIP: begin
        if (cnt_q == SKIP_BITS'(1)) begin
          if (can_pop) begin
            pop     = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - SKIP_BITS'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_div_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      ba_q   <= '0;
      rcw_q  <= '1;
      cs_n_q <= 1'b1;
      odt_q  <= 1'b0;
      cke_q  <= 1'b0;
      tz_q   <= 1'b1;
    end else begin
      cke_q <= cke_i;
      tz_q  <= ~en_i;
      if (state_q == ST_ISSUE) begin
        addr_q <= cur_q.addr;
        ba_q   <= cur_q.ba;
        rcw_q  <= cur_q.rcw;
        cs_n_q <= 1'b0;
        odt_q  <= cur_q.odt;
      end else begin
        rcw_q  <= '1;
        cs_n_q <= 1'b1;
      end
    end
  end

  // Lane order LSB first: addr, ba, we_n, cas_n, ras_n, cs_n, cke, odt.
  assign pin_val = {odt_q, cke_q, cs_n_q, rcw_q, ba_q, addr_q};
  assign pin_tz  = {tz_q, 1'b0, {(NUM_PINS-2){tz_q}}};

  always_comb begin
    cmda_din_o = '0;
    cmda_tin_o = '0;
    for (int unsigned i = 0; i < NUM_PINS; i++) begin
      cmda_din_o[4*i +: 4] = {4{pin_val[i]}};
      cmda_tin_o[4*i +: 4] = {4{pin_tz[i]}};
    end
  end

  assign busy_o       = ~empty | (state_q != ST_IDLE);
  assign fifo_level_o = level;

endmodule

// File: tb/tb_cmda_cmd_seq.sv
// Scoreboard bench for cmda_cmd_seq: queued commands are matched against issue cycles on cmda_din.
module tb_cmda_cmd_seq;
  localparam int A  = 15;
  localparam int NP = A + 9;
  localparam int L  = 4;

  logic            clk = 1'b0;
  logic            rst_n, en, cke;
  logic [NP*4-1:0] din, tin;
  logic            busy;
  logic [L:0]      level;

  cmda_cmd_seq_if #(.ADDRESS_NUMBER(A), .SKIP_BITS(8)) cif ();

  cmda_cmd_seq #(.ADDRESS_NUMBER(A), .FIFO_DEPTH_LOG2(L), .SKIP_BITS(8)) dut (
    .clk_div_i    (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .cke_i        (cke),
    .cmd          (cif),
    .cmda_din_o   (din),
    .cmda_tin_o   (tin),
    .busy_o       (busy),
    .fifo_level_o (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   rcw;
    logic [2:0]   ba;
    logic [A-1:0] addr;
    logic         odt;
    logic [7:0]   skip;
  } cmd_t;

  cmd_t         exp_q[$];
  int           issue_cyc[$];
  int           checks = 0, errors = 0, cyc = 0, issued = 0, nop_run = 0, last_gap = 0;
  logic         prev_valid = 1'b0;
  logic [7:0]   prev_skip = '0;
  logic [A-1:0] last_addr = '0;
  logic [2:0]   last_ba = '0;
  logic         last_odt = 1'b0;

  function automatic logic [NP*4-1:0] reset_din();
    logic [NP*4-1:0] v;
    v = '0;
    for (int i = A + 3; i <= A + 6; i++) v[4*i +: 4] = 4'hF;
    return v;
  endfunction

  function automatic logic [NP*4-1:0] reset_tin();
    logic [NP*4-1:0] v;
    v = '1;
    v[4*(A+7) +: 4] = 4'h0;
    return v;
  endfunction

  // One clock of the scoreboard monitor: decodes lanes and matches issues against exp_q.
  task automatic step();
    logic            en_s, cke_s, bad, cs, ck, od;
    logic [NP*4-1:0] exp_tin;
    logic [A-1:0]    a;
    logic [2:0]      b, r;
    cmd_t            e;
    en_s  = en;
    cke_s = cke;
    @(negedge clk);
    cyc++;
    if (!rst_n) return;
    bad = 1'b0;
    for (int i = 0; i < NP; i++)
      if (din[4*i +: 4] !== 4'h0 && din[4*i +: 4] !== 4'hF) bad = 1'b1;
    for (int i = 0; i < A; i++) a[i] = din[4*i];
    for (int j = 0; j < 3; j++) b[j] = din[4*(A+j)];
    r  = {din[4*(A+5)], din[4*(A+4)], din[4*(A+3)]};
    cs = din[4*(A+6)];
    ck = din[4*(A+7)];
    od = din[4*(A+8)];
    for (int i = 0; i < NP; i++) exp_tin[4*i +: 4] = (i == A + 7) ? 4'h0 : {4{~en_s}};
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL nibble_uniform cyc %0d din %h", cyc, din); end
    checks++;
    if (tin !== exp_tin) begin errors++; $display("FAIL tin cyc %0d got %h want %h", cyc, tin, exp_tin); end
    checks++;
    if (ck !== cke_s) begin errors++; $display("FAIL cke_lane cyc %0d got %b want %b", cyc, ck, cke_s); end
    if (cs === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue cyc %0d got rcw %b ba %0d addr %h want none", cyc, r, b, a);
        e.skip = '0;
      end else begin
        e = exp_q.pop_front();
        if ({r, b, a, od} !== {e.rcw, e.ba, e.addr, e.odt}) begin
          errors++;
          $display("FAIL issue cyc %0d got rcw %b ba %0d addr %h odt %b want rcw %b ba %0d addr %h odt %b",
                   cyc, r, b, a, od, e.rcw, e.ba, e.addr, e.odt);
        end
      end
      if (prev_valid) begin
        checks++;
        if (nop_run < int'(prev_skip)) begin
          errors++; $display("FAIL min_gap cyc %0d got %0d want >= %0d", cyc, nop_run, prev_skip);
        end
      end
      last_gap = nop_run; nop_run = 0; prev_valid = 1'b1; prev_skip = e.skip;
      last_addr = a; last_ba = b; last_odt = od;
      issued++;
      issue_cyc.push_back(cyc);
    end else begin
      nop_run++;
      checks++;
      if ({r, cs} !== 4'hF || a !== last_addr || b !== last_ba || od !== last_odt) begin
        errors++;
        $display("FAIL nop_hold cyc %0d got rcw %b cs %b addr %h ba %0d odt %b want 111 1 addr %h ba %0d odt %b",
                 cyc, r, cs, a, b, od, last_addr, last_ba, last_odt);
      end
    end
  endtask

  task automatic push(input logic [2:0] rcw, input logic [2:0] ba, input logic [A-1:0] addr,
                      input logic odt, input logic [7:0] skip, input logic accept);
    cmd_t e;
    cif.cmd_valid = 1'b1; cif.cmd_rcw = rcw; cif.cmd_ba = ba;
    cif.cmd_addr  = addr; cif.cmd_odt = odt; cif.cmd_skip = skip;
    checks++;
    if (cif.cmd_ready !== accept) begin
      errors++; $display("FAIL cmd_ready got %b want %b", cif.cmd_ready, accept);
    end
    if (accept) begin
      e = '{rcw, ba, addr, odt, skip};
      exp_q.push_back(e);
    end
    step();
    cif.cmd_valid = 1'b0;
  endtask

  task automatic wait_issues(input int target, input int budget);
    for (int n = 0; n < budget && issued < target; n++) step();
    checks++;
    if (issued < target) begin errors++; $display("FAIL issue_timeout got %0d want %0d", issued, target); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; cke = 1'b0;
    cif.cmd_valid = 1'b0; cif.cmd_rcw = '0; cif.cmd_ba = '0;
    cif.cmd_addr = '0; cif.cmd_odt = 1'b0; cif.cmd_skip = '0;
    #23;
    checks++; if (din !== reset_din()) begin errors++; $display("FAIL rst_din got %h want %h", din, reset_din()); end
    checks++; if (tin !== reset_tin()) begin errors++; $display("FAIL rst_tin got %h want %h", tin, reset_tin()); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL rst_level got %0d want 0", level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (cif.cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", cif.cmd_ready); end
    @(negedge clk);
    rst_n = 1'b1; cke = 1'b1; en = 1'b1;
    repeat (3) step();
    checks++; if (cif.cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_rst got %b want 1", cif.cmd_ready); end
  endtask

  task automatic test_act_read();
    int base, pc;
    base = issued;
    push(3'b011, 3'd2, 15'h1234, 1'b0, 8'd3, 1'b1);
    pc = cyc;
    push(3'b101, 3'd2, 15'h0040, 1'b0, 8'd0, 1'b1);
    wait_issues(base + 2, 40);
    if (issued >= base + 2) begin
      checks++;
      if (issue_cyc[base] !== pc + 2) begin errors++; $display("FAIL act_latency got %0d want %0d", issue_cyc[base], pc + 2); end
      checks++;
      if (issue_cyc[base+1] - issue_cyc[base] !== 4) begin
        errors++; $display("FAIL act_read_spacing got %0d want 4", issue_cyc[base+1] - issue_cyc[base]);
      end
    end
    checks++; if (last_gap !== 3) begin errors++; $display("FAIL act_nop_count got %0d want 3", last_gap); end
  endtask

  task automatic test_back_to_back();
    int base;
    base = issued;
    for (int i = 0; i < 4; i++) push(3'b100, 3'(i), 15'(16'h0200 + i), 1'b0, 8'd0, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_mid got %b want 1", busy); end
    wait_issues(base + 4, 40);
    if (issued >= base + 4) begin
      checks++;
      if (issue_cyc[base+3] - issue_cyc[base] !== 3) begin
        errors++; $display("FAIL b2b_span got %0d want 3", issue_cyc[base+3] - issue_cyc[base]);
      end
    end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b want 0", busy); end
  endtask

  task automatic test_full();
    int base;
    en = 1'b0;
    step();
    base = issued;
    for (int i = 0; i < 16; i++) push(3'(i % 8), 3'(i % 5), 15'(16'h0100 + 7 * i), 1'(i % 2), 8'd0, 1'b1);
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_level got %0d want 16", level); end
    push(3'b010, 3'd7, 15'h7FFF, 1'b1, 8'd0, 1'b0);
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_level_after17 got %0d want 16", level); end
    repeat (3) step();
    checks++; if (issued !== base) begin errors++; $display("FAIL full_no_issue got %0d want %0d", issued, base); end
    en = 1'b1;
    wait_issues(base + 16, 60);
    if (issued >= base + 16) begin
      checks++;
      if (issue_cyc[base+15] - issue_cyc[base] !== 15) begin
        errors++; $display("FAIL full_drain_span got %0d want 15", issue_cyc[base+15] - issue_cyc[base]);
      end
    end
    repeat (3) step();
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL full_drained_level got %0d want 0", level); end
  endtask

  task automatic test_en_drop();
    int base;
    en = 1'b0;
    step();
    base = issued;
    push(3'b011, 3'd1, 15'h0AAA, 1'b0, 8'd5, 1'b1);
    push(3'b101, 3'd1, 15'h0AB0, 1'b0, 8'd0, 1'b1);
    push(3'b101, 3'd1, 15'h0AB8, 1'b0, 8'd0, 1'b1);
    en = 1'b1;
    wait_issues(base + 1, 20);
    step(); step();
    en = 1'b0;
    repeat (10) step();
    checks++; if (issued !== base + 1) begin errors++; $display("FAIL endrop_issued got %0d want %0d", issued, base + 1); end
    checks++; if (level !== 5'd2) begin errors++; $display("FAIL endrop_level got %0d want 2", level); end
    en = 1'b1;
    wait_issues(base + 3, 30);
    repeat (2) step();
  endtask

  task automatic test_reset_mid();
    int base;
    en = 1'b0;
    step();
    base = issued;
    push(3'b011, 3'd4, 15'h0555, 1'b1, 8'd8, 1'b1);
    for (int i = 0; i < 3; i++) push(3'b101, 3'd4, 15'(16'h0560 + i), 1'b0, 8'd0, 1'b1);
    en = 1'b1;
    wait_issues(base + 1, 20);
    step(); step();
    rst_n = 1'b0;
    #1;
    checks++; if (din !== reset_din()) begin errors++; $display("FAIL midrst_din got %h want %h", din, reset_din()); end
    checks++; if (tin !== reset_tin()) begin errors++; $display("FAIL midrst_tin got %h want %h", tin, reset_tin()); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL midrst_level got %0d want 0", level); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (cif.cmd_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b want 0", cif.cmd_ready); end
    exp_q.delete();
    prev_valid = 1'b0; nop_run = 0;
    last_addr = '0; last_ba = '0; last_odt = 1'b0;
    step(); step();
    rst_n = 1'b1;
    base = issued;
    repeat (20) step();
    checks++; if (issued !== base) begin errors++; $display("FAIL midrst_no_issue got %0d want %0d", issued, base); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy_after got %b want 0", busy); end
  endtask

  task automatic test_odt();
    int base;
    base = issued;
    push(3'b100, 3'd3, 15'h0321, 1'b1, 8'd4, 1'b1);
    push(3'b011, 3'd0, 15'h0010, 1'b0, 8'd0, 1'b1);
    wait_issues(base + 1, 20);
    checks++; if (din[4*(A+8) +: 4] !== 4'hF) begin errors++; $display("FAIL odt_on_write got %h want f", din[4*(A+8) +: 4]); end
    for (int n = 0; n < 4; n++) begin
      step();
      checks++;
      if (din[4*(A+8) +: 4] !== 4'hF || din[4*(A+6) +: 4] !== 4'hF) begin
        errors++; $display("FAIL odt_nop%0d got odt %h cs %h want f f", n, din[4*(A+8) +: 4], din[4*(A+6) +: 4]);
      end
    end
    step();
    checks++; if (issued !== base + 2) begin errors++; $display("FAIL odt_next_issue got %0d want %0d", issued, base + 2); end
    checks++; if (din[4*(A+8) +: 4] !== 4'h0) begin errors++; $display("FAIL odt_off got %h want 0", din[4*(A+8) +: 4]); end
    repeat (2) step();
  endtask

  initial begin
    test_reset();
    test_act_read();
    test_back_to_back();
    test_full();
    test_en_drop();
    test_odt();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_expected got %0d want 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
